// File: rtl/mem_stage_multilane_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_multilane_pkg
//  Description : Shared record layouts and load-type bit indices for the
//                multi-lane memory-response stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_multilane_pkg;

    // Lane record from pre-mem, MSB first.
    typedef struct packed {
        logic        lane_valid;
        logic [6:0]  ls_type;
        logic [1:0]  offset;
        logic        res_from_mem;
        logic        mem_we;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] rt_value;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } lane_in_t;

    localparam int LIN_WD  = $bits(lane_in_t);
    // {lane_valid, gr_we, dest, result, pc}
    localparam int LOUT_WD = 1 + 1 + 5 + 32 + 32;
    // {mem_ok, res_from_mem, gr_we, dest, result}
    localparam int FWD_WD  = 1 + 1 + 1 + 5 + 32;

    localparam int LS_LB  = 6;
    localparam int LS_LBU = 5;
    localparam int LS_LH  = 4;
    localparam int LS_LHU = 3;
    localparam int LS_LW  = 2;
    localparam int LS_LWL = 1;
    localparam int LS_LWR = 0;

endpackage
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_load_align
//  Description : Combinational load-data alignment (lb/lbu/lh/lhu/lw/lwl/lwr).
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_load_align
    import mem_stage_multilane_pkg::*;
(
    input  logic [6:0]  i_ls_type,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_rt,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_offset)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_result = i_rdata;
        if (i_ls_type[LS_LB]) begin
            o_result = {{24{w_byte[7]}}, w_byte};
        end else if (i_ls_type[LS_LBU]) begin
            o_result = {24'h0, w_byte};
        end else if (i_ls_type[LS_LH]) begin
            o_result = {{16{w_half[15]}}, w_half};
        end else if (i_ls_type[LS_LHU]) begin
            o_result = {16'h0, w_half};
        end else if (i_ls_type[LS_LWL]) begin
            case (i_offset)
                2'd0: o_result = {i_rdata[7:0],  i_rt[23:0]};
                2'd1: o_result = {i_rdata[15:0], i_rt[15:0]};
                2'd2: o_result = {i_rdata[23:0], i_rt[7:0]};
                default: o_result = i_rdata;
            endcase
        end else if (i_ls_type[LS_LWR]) begin
            case (i_offset)
                2'd1: o_result = {i_rt[31:24], i_rdata[31:8]};
                2'd2: o_result = {i_rt[31:16], i_rdata[31:16]};
                2'd3: o_result = {i_rt[31:8],  i_rdata[31:24]};
                default: o_result = i_rdata;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage_multilane.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_multilane
//  Description : LANES-wide memory-response stage between pre-mem and WB with
//                early-response holding and flushed-response dropping.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_multilane
    import mem_stage_multilane_pkg::*;
#(
    parameter int LANES    = 2,
    parameter int MAX_DROP = 3
)
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      ws_allowin,
    output logic                      ms_allowin,
    input  logic                      pms_to_ms_valid,
    input  logic [LANES*LIN_WD-1:0]   pms_to_ms_bus,
    output logic                      ms_to_ws_valid,
    output logic [LANES*LOUT_WD-1:0]  ms_to_ws_bus,
    output logic [LANES*FWD_WD:0]     ms_forward_bus,
    input  logic [LANES-1:0]          dc_data_ok,
    input  logic [LANES*32-1:0]       dc_rdata
);

    localparam int                DROP_W   = $clog2(MAX_DROP + 1);
    localparam logic [DROP_W-1:0] DROP_MAX = DROP_W'(MAX_DROP);

    logic                     r_ms_valid;
    logic [LANES*LIN_WD-1:0]  r_bus;
    logic [LANES-1:0]         w_lane_ready;
    logic                     w_ready_go;
    logic                     w_latch;

    assign w_ready_go     = &w_lane_ready;
    assign ms_allowin     = !r_ms_valid | (w_ready_go & ws_allowin);
    assign ms_to_ws_valid = r_ms_valid & w_ready_go & !flush;
    assign w_latch        = pms_to_ms_valid & ms_allowin & !flush;

    assign ms_forward_bus[LANES*FWD_WD] = r_ms_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ms_valid <= 1'b0;
        end else if (flush) begin
            r_ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            r_ms_valid <= pms_to_ms_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_latch) begin
            r_bus <= pms_to_ms_bus;
        end
    end

    genvar k;
    generate
        for (k = 0; k < LANES; k = k + 1) begin : g_lane
            lane_in_t          w_in;
            logic              w_lane_valid;
            logic              w_mem_req;
            logic              w_drop_pending;
            logic              w_consume;
            logic              w_live_ok;
            logic              w_capture;
            logic              w_inc;
            logic [31:0]       w_aligned;
            logic [31:0]       w_result;
            logic              r_mem_ok;
            logic [31:0]       r_hold;
            logic [DROP_W-1:0] r_drop_cnt;

            assign w_in         = lane_in_t'(r_bus[k*LIN_WD +: LIN_WD]);
            // Lane 0 is the group's anchor and is always considered populated.
            assign w_lane_valid = w_in.lane_valid | (k == 0);
            assign w_mem_req    = w_lane_valid & (w_in.res_from_mem | w_in.mem_we);

            assign w_drop_pending  = (r_drop_cnt != '0);
            assign w_consume       = dc_data_ok[k] & w_drop_pending;
            assign w_live_ok       = dc_data_ok[k] & !w_drop_pending;
            assign w_lane_ready[k] = !w_mem_req | r_mem_ok | w_live_ok;

            // ms_allowin is low only while a valid group stalls here.
            assign w_capture = r_ms_valid & w_mem_req & !r_mem_ok & w_live_ok & !ms_allowin;
            // A response arriving in the flush cycle answers the killed request.
            assign w_inc     = flush & r_ms_valid & w_mem_req & !r_mem_ok & !dc_data_ok[k];

            mem_load_align u_align (
                .i_ls_type (w_in.ls_type),
                .i_offset  (w_in.offset),
                .i_rdata   (dc_rdata[k*32 +: 32]),
                .i_rt      (w_in.rt_value),
                .o_result  (w_aligned)
            );

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_mem_ok <= 1'b0;
                end else if (flush | ms_allowin) begin
                    r_mem_ok <= 1'b0;
                end else if (w_capture) begin
                    r_mem_ok <= 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (w_capture && w_in.res_from_mem) begin
                    r_hold <= w_aligned;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_drop_cnt <= '0;
                end else if (w_inc && !w_consume) begin
                    if (r_drop_cnt != DROP_MAX) begin
                        r_drop_cnt <= r_drop_cnt + 1'b1;
                    end
                end else if (w_consume && !w_inc) begin
                    r_drop_cnt <= r_drop_cnt - 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (!reset && w_inc && !w_consume) begin
                    assert (r_drop_cnt != DROP_MAX)
                        else $error("drop counter overflow on lane %0d", k);
                end
            end

            // Stores never fill hold, so their result stays on the ALU path.
            assign w_result = (r_mem_ok & w_in.res_from_mem) ? r_hold :
                              w_in.res_from_mem              ? w_aligned :
                                                               w_in.alu_result;

            assign ms_to_ws_bus[k*LOUT_WD +: LOUT_WD] =
                {w_lane_valid, w_in.gr_we & w_lane_valid, w_in.dest, w_result, w_in.pc};

            assign ms_forward_bus[k*FWD_WD +: FWD_WD] =
                {w_mem_req & (r_mem_ok | w_live_ok),
                 w_in.res_from_mem & w_lane_valid,
                 w_in.gr_we & w_lane_valid,
                 w_in.dest,
                 w_result};
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_multilane.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage_multilane
//  Description : Directed bench for mem_stage_multilane (2-lane and 4-lane builds).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_multilane;

    localparam logic [6:0] LB  = 7'b1000000;
    localparam logic [6:0] LBU = 7'b0100000;
    localparam logic [6:0] LH  = 7'b0010000;
    localparam logic [6:0] LHU = 7'b0001000;
    localparam logic [6:0] LW  = 7'b0000100;
    localparam logic [6:0] LWL = 7'b0000010;
    localparam logic [6:0] LWR = 7'b0000001;
    localparam logic [6:0] NONE = 7'b0000000;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic         flush2, ws2, allow2, pvalid2, wsvalid2;
    logic [227:0] pbus2;
    logic [141:0] wsbus2;
    logic [80:0]  fwd2;
    logic [1:0]   dok2;
    logic [63:0]  rd2;

    logic         flush4, ws4, allow4, pvalid4, wsvalid4;
    logic [455:0] pbus4;
    logic [283:0] wsbus4;
    logic [160:0] fwd4;
    logic [3:0]   dok4;
    logic [127:0] rd4;

    mem_stage_multilane #(.LANES(2), .MAX_DROP(3)) dut2 (
        .clk(clk), .reset(reset), .flush(flush2), .ws_allowin(ws2), .ms_allowin(allow2),
        .pms_to_ms_valid(pvalid2), .pms_to_ms_bus(pbus2), .ms_to_ws_valid(wsvalid2),
        .ms_to_ws_bus(wsbus2), .ms_forward_bus(fwd2), .dc_data_ok(dok2), .dc_rdata(rd2));

    mem_stage_multilane #(.LANES(4), .MAX_DROP(3)) dut4 (
        .clk(clk), .reset(reset), .flush(flush4), .ws_allowin(ws4), .ms_allowin(allow4),
        .pms_to_ms_valid(pvalid4), .pms_to_ms_bus(pbus4), .ms_to_ws_valid(wsvalid4),
        .ms_to_ws_bus(wsbus4), .ms_forward_bus(fwd4), .dc_data_ok(dok4), .dc_rdata(rd4));

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic logic [113:0] mk(input logic v, input logic [6:0] ls, input logic [1:0] off,
                                         input logic rfm, input logic mwe, input logic gwe,
                                         input logic [4:0] dst, input logic [31:0] rt,
                                         input logic [31:0] alu, input logic [31:0] pc);
        return {v, ls, off, rfm, mwe, gwe, dst, rt, alu, pc};
    endfunction

    function automatic logic [31:0] res2(input int k);
        return wsbus2[k*71+32 +: 32];
    endfunction
    function automatic logic [31:0] res4(input int k);
        return wsbus4[k*71+32 +: 32];
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [6:0]  ls;
        logic [1:0]  off;
        logic [31:0] rt;
        logic [31:0] rd;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    vec_t tv[16];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tv[0]  = '{LB,  2'd0, 32'h11223344, 32'hAABBCCDD, 32'hFFFFFFDD, "lb_o0"};
        tv[1]  = '{LBU, 2'd1, 32'h11223344, 32'hAABBCCDD, 32'h000000CC, "lbu_o1"};
        tv[2]  = '{LB,  2'd2, 32'h11223344, 32'hAABBCCDD, 32'hFFFFFFBB, "lb_o2"};
        tv[3]  = '{LBU, 2'd3, 32'h11223344, 32'hAABBCCDD, 32'h000000AA, "lbu_o3"};
        tv[4]  = '{LB,  2'd0, 32'h11223344, 32'h12345678, 32'h00000078, "lb_pos"};
        tv[5]  = '{LH,  2'd0, 32'h11223344, 32'hAABBCCDD, 32'hFFFFCCDD, "lh_o0"};
        tv[6]  = '{LHU, 2'd2, 32'h11223344, 32'hAABBCCDD, 32'h0000AABB, "lhu_o2"};
        tv[7]  = '{LH,  2'd2, 32'h11223344, 32'h12345678, 32'h00001234, "lh_pos"};
        tv[8]  = '{LW,  2'd0, 32'h11223344, 32'h800000F1, 32'h800000F1, "lw"};
        tv[9]  = '{LWL, 2'd0, 32'h11223344, 32'hAABBCCDD, 32'hDD223344, "lwl_o0"};
        tv[10] = '{LWL, 2'd2, 32'h11223344, 32'hAABBCCDD, 32'hBBCCDD44, "lwl_o2"};
        tv[11] = '{LWL, 2'd3, 32'h11223344, 32'hAABBCCDD, 32'hAABBCCDD, "lwl_o3"};
        tv[12] = '{LWR, 2'd0, 32'h11223344, 32'hAABBCCDD, 32'hAABBCCDD, "lwr_o0"};
        tv[13] = '{LWR, 2'd1, 32'h11223344, 32'hAABBCCDD, 32'h11AABBCC, "lwr_o1"};
        tv[14] = '{LWR, 2'd3, 32'h11223344, 32'hAABBCCDD, 32'h112233AA, "lwr_o3"};
        tv[15] = '{LHU, 2'd0, 32'h11223344, 32'h0000FFFE, 32'h0000FFFE, "lhu_o0"};

        reset = 1'b1;
        flush2 = 0; ws2 = 1; pvalid2 = 0; pbus2 = '0; dok2 = 0; rd2 = '0;
        flush4 = 0; ws4 = 1; pvalid4 = 0; pbus4 = '0; dok4 = 0; rd4 = '0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_allowin2", {31'b0, allow2}, 32'h1);
        chk("rst_valid2",   {31'b0, wsvalid2}, 32'h0);
        chk("rst_fwdv2",    {31'b0, fwd2[80]}, 32'h0);
        chk("rst_allowin4", {31'b0, allow4}, 32'h1);
        chk("rst_valid4",   {31'b0, wsvalid4}, 32'h0);

        // Alignment table: lane0 load, data_ok on the first cycle in stage.
        for (int i = 0; i < 16; i++) begin
            next_cycle();
            pbus2 = {mk(1'b0, LW, 2'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0),
                     mk(1'b1, tv[i].ls, tv[i].off, 1'b1, 1'b0, 1'b1, 5'd3, tv[i].rt, 32'h0, 32'h1000)};
            pvalid2 = 1'b1;
            ws2 = 1'b1;
            next_cycle();
            pvalid2 = 1'b0;
            dok2 = 2'b01;
            rd2 = {32'h0, tv[i].rd};
            @(negedge clk);
            chk({tv[i].nm, "_valid"}, {31'b0, wsvalid2}, 32'h1);
            chk({tv[i].nm, "_res"}, res2(0), tv[i].exp);
            if (i == 0) chk("lane1_invalid_bit", {31'b0, wsbus2[71+70]}, 32'h0);
            next_cycle();
            dok2 = 2'b00;
        end

        // Early lane1 response held across 4 backpressure cycles.
        pbus2 = {mk(1'b1, LB, 2'd3, 1'b1, 1'b0, 1'b1, 5'd7, 32'h0, 32'h0, 32'h2004),
                 mk(1'b1, NONE, 2'd0, 1'b0, 1'b0, 1'b1, 5'd2, 32'h0, 32'hA1A2A3A4, 32'h2000)};
        pvalid2 = 1'b1;
        next_cycle();
        pvalid2 = 1'b0;
        ws2 = 1'b0;
        dok2 = 2'b10;
        rd2 = {32'h80123456, 32'h0};
        @(negedge clk);
        chk("hold_stall_allowin", {31'b0, allow2}, 32'h0);
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            dok2 = 2'b00;
            rd2 = '0;
            @(negedge clk);
            chk("hold_memok_fwd", {31'b0, fwd2[40+39]}, 32'h1);
            chk("hold_res", res2(1), 32'hFFFFFF80);
        end
        next_cycle();
        ws2 = 1'b1;
        @(negedge clk);
        chk("hold_rel_valid", {31'b0, wsvalid2}, 32'h1);
        chk("hold_rel_res1",  res2(1), 32'hFFFFFF80);
        chk("hold_rel_res0",  res2(0), 32'hA1A2A3A4);
        next_cycle();
        @(negedge clk);
        chk("hold_after_empty", {31'b0, fwd2[80]}, 32'h0);

        // lwr / lwl side by side.
        next_cycle();
        pbus2 = {mk(1'b1, LWL, 2'd1, 1'b1, 1'b0, 1'b1, 5'd9, 32'h11223344, 32'h0, 32'h3004),
                 mk(1'b1, LWR, 2'd2, 1'b1, 1'b0, 1'b1, 5'd8, 32'h11223344, 32'h0, 32'h3000)};
        pvalid2 = 1'b1;
        next_cycle();
        pvalid2 = 1'b0;
        dok2 = 2'b11;
        rd2 = {32'hAABBCCDD, 32'hAABBCCDD};
        @(negedge clk);
        chk("lwr_lwl_valid", {31'b0, wsvalid2}, 32'h1);
        chk("lane0_lwr_o2", res2(0), 32'h1122AABB);
        chk("lane1_lwl_o1", res2(1), 32'hCCDD3344);
        next_cycle();
        dok2 = 2'b00;

        // Flush with both lanes outstanding, then a stale lane1 response is dropped.
        pbus2 = {mk(1'b1, LW, 2'd0, 1'b1, 1'b0, 1'b1, 5'd4, 32'h0, 32'h0, 32'h4004),
                 mk(1'b1, LB, 2'd0, 1'b1, 1'b0, 1'b1, 5'd5, 32'h0, 32'h0, 32'h4000)};
        pvalid2 = 1'b1;
        next_cycle();
        pvalid2 = 1'b0;
        @(negedge clk);
        chk("fl_wait_valid", {31'b0, wsvalid2}, 32'h0);
        next_cycle();
        flush2 = 1'b1;
        pvalid2 = 1'b1;
        pbus2 = {mk(1'b1, NONE, 2'd0, 1'b0, 1'b0, 1'b1, 5'd1, 32'h0, 32'h77, 32'h0),
                 mk(1'b1, NONE, 2'd0, 1'b0, 1'b0, 1'b1, 5'd1, 32'h0, 32'h66, 32'h0)};
        @(negedge clk);
        chk("fl_cycle_valid", {31'b0, wsvalid2}, 32'h0);
        next_cycle();
        flush2 = 1'b0;
        pvalid2 = 1'b0;
        @(negedge clk);
        chk("fl_after_allowin", {31'b0, allow2}, 32'h1);
        chk("fl_after_fwdv", {31'b0, fwd2[80]}, 32'h0);
        next_cycle();
        pbus2 = {mk(1'b1, LW, 2'd0, 1'b1, 1'b0, 1'b1, 5'd6, 32'h0, 32'h0, 32'h5004),
                 mk(1'b1, NONE, 2'd0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0, 32'h00000055, 32'h5000)};
        pvalid2 = 1'b1;
        next_cycle();
        pvalid2 = 1'b0;
        dok2 = 2'b11;
        rd2 = {32'hDEAD0000, 32'hDEAD1111};
        @(negedge clk);
        chk("drop_stale_valid", {31'b0, wsvalid2}, 32'h0);
        next_cycle();
        dok2 = 2'b10;
        rd2 = {32'h13579BDF, 32'h0};
        @(negedge clk);
        chk("drop_second_valid", {31'b0, wsvalid2}, 32'h1);
        chk("drop_second_res1", res2(1), 32'h13579BDF);
        chk("drop_second_res0", res2(0), 32'h00000055);
        next_cycle();
        dok2 = 2'b00;

        // Flush coinciding with lane0 data_ok: only lane1 owes a dropped response.
        pbus2 = {mk(1'b1, LW, 2'd0, 1'b1, 1'b0, 1'b1, 5'd4, 32'h0, 32'h0, 32'h6004),
                 mk(1'b1, LW, 2'd0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h0, 32'h0, 32'h6000)};
        pvalid2 = 1'b1;
        next_cycle();
        pvalid2 = 1'b0;
        flush2 = 1'b1;
        dok2 = 2'b01;
        rd2 = {32'h0, 32'hBAD0BAD0};
        @(negedge clk);
        chk("flok_cycle_valid", {31'b0, wsvalid2}, 32'h0);
        next_cycle();
        flush2 = 1'b0;
        dok2 = 2'b00;
        pbus2 = {mk(1'b1, NONE, 2'd0, 1'b0, 1'b0, 1'b1, 5'd4, 32'h0, 32'h99, 32'h7004),
                 mk(1'b1, LW, 2'd0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h0, 32'h0, 32'h7000)};
        pvalid2 = 1'b1;
        next_cycle();
        pvalid2 = 1'b0;
        dok2 = 2'b01;
        rd2 = {32'h0, 32'h600DF00D};
        @(negedge clk);
        chk("flok_lane0_valid", {31'b0, wsvalid2}, 32'h1);
        chk("flok_lane0_res", res2(0), 32'h600DF00D);
        next_cycle();
        dok2 = 2'b00;
        pbus2 = {mk(1'b1, LW, 2'd0, 1'b1, 1'b0, 1'b1, 5'd4, 32'h0, 32'h0, 32'h8004),
                 mk(1'b1, NONE, 2'd0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0, 32'h44, 32'h8000)};
        pvalid2 = 1'b1;
        next_cycle();
        pvalid2 = 1'b0;
        dok2 = 2'b10;
        rd2 = {32'hBAD1BAD1, 32'h0};
        @(negedge clk);
        chk("flok_lane1_drop", {31'b0, wsvalid2}, 32'h0);
        next_cycle();
        rd2 = {32'h24681357, 32'h0};
        @(negedge clk);
        chk("flok_lane1_valid", {31'b0, wsvalid2}, 32'h1);
        chk("flok_lane1_res", res2(1), 32'h24681357);
        next_cycle();
        dok2 = 2'b00;

        // Four-lane build: invalid lane2, store on lane3 answered two cycles late.
        pbus4 = {mk(1'b1, NONE, 2'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'hCAFE0000, 32'h00002000, 32'h900C),
                 mk(1'b0, LW,   2'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h9008),
                 mk(1'b1, NONE, 2'd0, 1'b0, 1'b0, 1'b1, 5'd2, 32'h0, 32'h00000022, 32'h9004),
                 mk(1'b1, NONE, 2'd0, 1'b0, 1'b0, 1'b1, 5'd1, 32'h0, 32'h00000011, 32'h9000)};
        pvalid4 = 1'b1;
        next_cycle();
        pvalid4 = 1'b0;
        dok4 = 4'b0100;
        @(negedge clk);
        chk("l4_wait1_valid", {31'b0, wsvalid4}, 32'h0);
        next_cycle();
        dok4 = 4'b0000;
        @(negedge clk);
        chk("l4_wait2_valid", {31'b0, wsvalid4}, 32'h0);
        next_cycle();
        dok4 = 4'b1000;
        @(negedge clk);
        chk("l4_retire_valid", {31'b0, wsvalid4}, 32'h1);
        chk("l4_lane2_vbit", {31'b0, wsbus4[2*71+70]}, 32'h0);
        chk("l4_lane3_vbit", {31'b0, wsbus4[3*71+70]}, 32'h1);
        chk("l4_lane3_res", res4(3), 32'h00002000);
        chk("l4_lane1_res", res4(1), 32'h00000022);
        next_cycle();
        dok4 = 4'b0000;
        @(negedge clk);
        chk("l4_empty", {31'b0, fwd4[160]}, 32'h0);

        // Build up a drop count, stall again, then reset mid-stall.
        next_cycle();
        pvalid4 = 1'b1;
        next_cycle();
        pvalid4 = 1'b0;
        flush4 = 1'b1;
        next_cycle();
        flush4 = 1'b0;
        pvalid4 = 1'b1;
        next_cycle();
        pvalid4 = 1'b0;
        @(negedge clk);
        chk("l4_stall_allowin", {31'b0, allow4}, 32'h0);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("l4_rst_valid", {31'b0, wsvalid4}, 32'h0);
        chk("l4_rst_allowin", {31'b0, allow4}, 32'h1);
        chk("l4_rst_fwdv", {31'b0, fwd4[160]}, 32'h0);
        next_cycle();
        pvalid4 = 1'b1;
        next_cycle();
        pvalid4 = 1'b0;
        dok4 = 4'b1000;
        @(negedge clk);
        chk("l4_postrst_valid", {31'b0, wsvalid4}, 32'h1);
        next_cycle();
        dok4 = 4'b0000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
